arith_accum_unit: RTL and testbench

Parametrised, registered add/subtract/accumulate unit with selectable unsigned or two's-complement overflow detection, optional saturation and a sticky overflow flag. It is the WIDTH-generic successor to the team's fixed 3-bit registered adder. It adds subtraction, an internal accumulator, a valid handshake and saturation. It sits between operand-producing datapath logic and downstream consumers that sample result and overflow on out_valid.

---
 rtl/arith_accum_unit.sv | 68 ++++++
 tb/tb_arith_accum_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/arith_accum_unit.sv
// arith_accum_unit: registered add/sub/accumulate with unsigned or signed overflow, optional saturation and sticky overflow.
//   clock, reset (async, active-high)
//   in_valid, op, operand1, operand2, mode (1 = signed), saturate, clear_sticky
//   out_valid, result, overflow, sticky_overflow, acc_value
module arith_accum_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [1:0]       op,
    input  logic             mode,
    input  logic             saturate,
    input  logic             clear_sticky,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             sticky_overflow,
    output logic [WIDTH-1:0] acc_value
);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] a, b, sat_val, res;
    logic [WIDTH:0]   sum;
    logic             sub, ovf_s, ovf;
    logic             out_valid_q, out_valid_d, overflow_q, overflow_d, sticky_q, sticky_d;
    logic [WIDTH-1:0] result_q, result_d, acc_q, acc_d;
    always_comb begin
        a       = op[1] ? acc_q : operand1;
        b       = op[1] ? operand1 : operand2;
        sub     = op == 2'b01;
        sum     = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        // Signed: add overflows on like-signed operands, sub on unlike-signed; either way the sign of a is lost.
        ovf_s   = (sub ? (a[WIDTH-1] != b[WIDTH-1]) : (a[WIDTH-1] == b[WIDTH-1])) && (sum[WIDTH-1] != a[WIDTH-1]);
        // Unsigned: bit WIDTH is the carry for add and the borrow for sub.
        ovf     = (op == 2'b11) ? 1'b0 : (mode ? ovf_s : sum[WIDTH]);
        // A signed overflow always goes in the direction of a's sign.
        sat_val = mode ? (a[WIDTH-1] ? SMIN : SMAX) : (sub ? '0 : '1);
        res     = (op == 2'b11) ? '0 : ((saturate && ovf) ? sat_val : sum[WIDTH-1:0]);
        out_valid_d = in_valid;
        result_d    = in_valid ? res : result_q;
        overflow_d  = in_valid ? ovf : overflow_q;
        acc_d       = (in_valid && op[1]) ? res : acc_q;
        sticky_d    = (in_valid && ovf) ? 1'b1 : (clear_sticky ? 1'b0 : sticky_q);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            sticky_q    <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            sticky_q    <= sticky_d;
            acc_q       <= acc_d;
        end
    end
    assign out_valid       = out_valid_q;
    assign result          = result_q;
    assign overflow        = overflow_q;
    assign sticky_overflow = sticky_q;
    assign acc_value       = acc_q;
endmodule

// File: tb/tb_arith_accum_unit.sv
// tb_arith_accum_unit: directed vectors with hand-computed expectations for arith_accum_unit (WIDTH=8).
module tb_arith_accum_unit;
    logic       clock = 1'b0, reset = 1'b1, in_valid = 1'b0, mode = 1'b0, saturate = 1'b0, clear_sticky = 1'b0;
    logic [7:0] operand1 = '0, operand2 = '0;
    logic [1:0] op = '0;
    logic       out_valid, overflow, sticky_overflow;
    logic [7:0] result, acc_value;
    int checks = 0, errors = 0;

    arith_accum_unit #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .operand1(operand1), .operand2(operand2),
        .op(op), .mode(mode), .saturate(saturate), .clear_sticky(clear_sticky),
        .out_valid(out_valid), .result(result), .overflow(overflow),
        .sticky_overflow(sticky_overflow), .acc_value(acc_value)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic v, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic m, input logic s, input logic c);
        in_valid = v; op = o; operand1 = x; operand2 = y; mode = m; saturate = s; clear_sticky = c;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valid", out_valid, 0); chk("rst_result", result, 0); chk("rst_ovf", overflow, 0);
        chk("rst_sticky", sticky_overflow, 0); chk("rst_acc", acc_value, 0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        // unsigned add 200+100
        run(1, 2'b00, 8'd200, 8'd100, 0, 0, 0);
        chk("uadd_wrap", result, 8'h2C); chk("uadd_wrap_ovf", overflow, 1);
        chk("uadd_sticky", sticky_overflow, 1); chk("uadd_valid", out_valid, 1); chk("uadd_acc", acc_value, 0);
        run(1, 2'b00, 8'd200, 8'd100, 0, 1, 0);
        chk("uadd_sat", result, 8'hFF); chk("uadd_sat_ovf", overflow, 1);
        // idle cycle with clear_sticky
        run(0, 2'b00, 8'd0, 8'd0, 0, 0, 1);
        chk("idle_sticky", sticky_overflow, 0); chk("idle_valid", out_valid, 0);
        chk("idle_hold", result, 8'hFF); chk("idle_hold_ovf", overflow, 1);
        // signed
        run(1, 2'b00, 8'd100, 8'd50, 1, 0, 0);
        chk("sadd_wrap", result, 8'h96); chk("sadd_wrap_ovf", overflow, 1);
        run(1, 2'b00, 8'd100, 8'd50, 1, 1, 0);
        chk("sadd_sat", result, 8'h7F); chk("sadd_sat_ovf", overflow, 1);
        run(1, 2'b01, 8'h9C, 8'd50, 1, 1, 0);
        chk("ssub_sat", result, 8'h80); chk("ssub_sat_ovf", overflow, 1);
        run(1, 2'b01, 8'd50, 8'hEC, 1, 1, 0);
        chk("ssub_ok", result, 8'h46); chk("ssub_ok_ovf", overflow, 0);
        // unsigned sub 5-7
        run(1, 2'b01, 8'd5, 8'd7, 0, 0, 0);
        chk("usub_wrap", result, 8'hFE); chk("usub_wrap_ovf", overflow, 1);
        run(1, 2'b01, 8'd5, 8'd7, 0, 1, 0);
        chk("usub_sat", result, 8'h00); chk("usub_sat_ovf", overflow, 1);
        // accumulate, wrap
        run(1, 2'b11, 8'd55, 8'd66, 0, 0, 0);
        chk("clr_result", result, 0); chk("clr_ovf", overflow, 0); chk("clr_valid", out_valid, 1); chk("clr_acc", acc_value, 0);
        run(1, 2'b10, 8'd100, 8'd0, 0, 0, 0);
        chk("accw1", acc_value, 100); chk("accw1_ovf", overflow, 0);
        run(1, 2'b10, 8'd100, 8'd0, 0, 0, 0);
        chk("accw2", acc_value, 200); chk("accw2_ovf", overflow, 0);
        run(1, 2'b10, 8'd100, 8'd0, 0, 0, 0);
        chk("accw3", acc_value, 44); chk("accw3_ovf", overflow, 1); chk("accw3_result", result, 44);
        // accumulate, saturate
        run(1, 2'b11, 8'd0, 8'd0, 0, 1, 0);
        chk("clr2_acc", acc_value, 0);
        run(1, 2'b10, 8'd100, 8'd0, 0, 1, 0);
        chk("accs1", acc_value, 100);
        run(1, 2'b10, 8'd100, 8'd0, 0, 1, 0);
        chk("accs2", acc_value, 200);
        run(1, 2'b10, 8'd100, 8'd0, 0, 1, 0);
        chk("accs3", acc_value, 255); chk("accs3_ovf", overflow, 1);
        // add must not touch accumulator
        run(1, 2'b00, 8'd1, 8'd2, 0, 0, 0);
        chk("add_keep_acc", acc_value, 255); chk("add_result", result, 3);
        // pulses then gap
        run(1, 2'b00, 8'd1, 8'd1, 0, 0, 0);
        chk("pulse1_valid", out_valid, 1); chk("pulse1_result", result, 2);
        run(1, 2'b00, 8'd2, 8'd2, 0, 0, 0);
        chk("pulse2_valid", out_valid, 1); chk("pulse2_result", result, 4);
        run(0, 2'b00, 8'd9, 8'd9, 0, 0, 0);
        chk("gap_valid", out_valid, 0); chk("gap_result", result, 4);
        // sticky set beats clear
        run(0, 2'b00, 8'd0, 8'd0, 0, 0, 1);
        chk("sticky_pre", sticky_overflow, 0);
        run(1, 2'b00, 8'd200, 8'd100, 0, 0, 1);
        chk("sticky_setwins", sticky_overflow, 1);
        run(0, 2'b00, 8'd0, 8'd0, 0, 0, 1);
        chk("sticky_clear", sticky_overflow, 0);
        // async reset mid-stream
        run(1, 2'b11, 8'd0, 8'd0, 0, 0, 0);
        run(1, 2'b10, 8'd200, 8'd0, 0, 0, 0);
        chk("pre_rst_acc", acc_value, 200);
        op = 2'b10; operand1 = 8'd10; in_valid = 1'b1; clear_sticky = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0); chk("arst_result", result, 0); chk("arst_acc", acc_value, 0);
        @(posedge clock); #1;
        chk("arst_hold_acc", acc_value, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_acc", acc_value, 10); chk("post_rst_valid", out_valid, 1); chk("post_rst_ovf", overflow, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
